// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int OP_W                = 6;
    localparam int DATA_W              = 64;
    localparam int ALU_LATENCY_DEFAULT = 2;
    localparam int TAG_W_DEFAULT       = 4;

    // The tag field is sized for the default tag width.
    // Wider request tags are truncated to this width.
    typedef struct packed {
        logic [OP_W-1:0]          op;
        logic [DATA_W-1:0]        a;
        logic [DATA_W-1:0]        b;
        logic [TAG_W_DEFAULT-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH register FIFO with synchronous clear.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: a push is ignored when full, and a pop is ignored when empty; clear wins over both.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests and issues one per cycle into the fixed-latency ALU wrapper, with tag tracking.
// Latency: a request accepted in cycle t issues in t+1, and its result is valid in t+1+ALU_LATENCY.
// Backpressure: in_ready is !full from registered occupancy; the result side cannot be back-pressured.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = alu_pkg::TAG_W_DEFAULT,
    parameter int ALU_LATENCY = alu_pkg::ALU_LATENCY_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [DATA_W-1:0]         in_a,
    input  logic [DATA_W-1:0]         in_b,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      stall,
    input  logic                      flush,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic [DATA_W-1:0]         alu_out,
    output logic                      res_valid,
    output logic [TAG_W-1:0]          res_tag,
    output logic [DATA_W-1:0]         res_data,
    output logic [$clog2(DEPTH):0]    count
);

    alu_req_t         push_req;
    alu_req_t         head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             issue;
    logic [TAG_W-1:0] head_tag;

    logic             vld_q [ALU_LATENCY];
    logic [TAG_W-1:0] tag_q [ALU_LATENCY];

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !flush;
    assign issue    = !fifo_empty && !stall && !flush;

    always_comb begin
        push_req     = '0;
        push_req.op  = in_op;
        push_req.a   = in_a;
        push_req.b   = in_b;
        push_req.tag = TAG_W_DEFAULT'(in_tag);
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(alu_req_t))
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .push_dat (push_req),
        .pop      (issue),
        .pop_dat  (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    assign head_tag = TAG_W'(head_req.tag);

    // Zero the wrapper inputs on idle cycles, so that a stale head is never shown downstream.
    assign alu_op = issue ? head_req.op : '0;
    assign alu_a  = issue ? head_req.a  : '0;
    assign alu_b  = issue ? head_req.b  : '0;

    // The wrapper has no enable, so this pipe advances every cycle; a flush only kills the valids.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ALU_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            tag_q[0] <= head_tag;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush;
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign res_valid = vld_q[ALU_LATENCY-1];
    assign res_tag   = tag_q[ALU_LATENCY-1];
    assign res_data  = alu_out;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue, with a two-stage ALU wrapper model driving alu_out.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int LAT   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid, in_ready, stall, flush;
    logic [5:0]        in_op, alu_op;
    logic [63:0]       in_a, in_b, alu_a, alu_b, alu_out, res_data;
    logic [TAG_W-1:0]  in_tag, res_tag;
    logic              res_valid;
    logic [2:0]        count;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .stall(stall), .flush(flush),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .count(count)
    );

    // Model of the registered wrapper: 1=add 2=sub 3=and 4=xor
    function automatic logic [63:0] alu_f(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a & b;
            6'd4:    return a ^ b;
            default: return 64'd0;
        endcase
    endfunction

    logic [63:0] m1, m2;
    always_ff @(posedge clock) begin
        m1 <= alu_f(alu_op, alu_a, alu_b);
        m2 <= m1;
    end
    assign alu_out = m2;

    typedef struct {
        logic v; logic [5:0] op; logic [63:0] a; logic [63:0] b; logic [3:0] tag; logic st; logic fl;
        logic e_rdy; logic [2:0] e_cnt; logic [5:0] e_op; logic [63:0] e_a; logic [63:0] e_b;
        logic e_rv; logic [3:0] e_rt; logic [63:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
        input logic [3:0] tag, input logic st, input logic fl,
        input logic e_rdy, input logic [2:0] e_cnt, input logic [5:0] e_op,
        input logic [63:0] e_a, input logic [63:0] e_b,
        input logic e_rv, input logic [3:0] e_rt, input logic [63:0] e_rd);
        vec_t r;
        r.v = v; r.op = op; r.a = a; r.b = b; r.tag = tag; r.st = st; r.fl = fl;
        r.e_rdy = e_rdy; r.e_cnt = e_cnt; r.e_op = e_op; r.e_a = e_a; r.e_b = e_b;
        r.e_rv = e_rv; r.e_rt = e_rt; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, input logic st, input logic fl);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; stall = st; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    vec_t vt[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Single request, then fill to full under stall and drain.
        //          v op a   b   tg st fl   rdy cnt eop ea  eb  rv rt rd
        vt[0]  = mk(1, 1, 5,  7,  3, 0, 0,  1, 0, 0, 0,  0,  0, 0, 0);
        vt[1]  = mk(0, 0, 0,  0,  0, 0, 0,  1, 1, 1, 5,  7,  0, 0, 0);
        vt[2]  = mk(0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0,  0,  0, 0, 0);
        vt[3]  = mk(0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0,  0,  1, 3, 12);
        vt[4]  = mk(0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0,  0,  0, 0, 0);
        vt[5]  = mk(1, 1, 10, 1,  0, 1, 0,  1, 0, 0, 0,  0,  0, 0, 0);
        vt[6]  = mk(1, 2, 10, 3,  1, 1, 0,  1, 1, 0, 0,  0,  0, 0, 0);
        vt[7]  = mk(1, 3, 12, 10, 2, 1, 0,  1, 2, 0, 0,  0,  0, 0, 0);
        vt[8]  = mk(1, 4, 6,  3,  3, 1, 0,  1, 3, 0, 0,  0,  0, 0, 0);
        vt[9]  = mk(1, 4, 9,  9,  4, 1, 0,  0, 4, 0, 0,  0,  0, 0, 0);
        vt[10] = mk(1, 4, 9,  9,  4, 0, 0,  0, 4, 1, 10, 1,  0, 0, 0);
        vt[11] = mk(0, 0, 0,  0,  0, 0, 0,  1, 3, 2, 10, 3,  0, 0, 0);
        vt[12] = mk(0, 0, 0,  0,  0, 0, 0,  1, 2, 3, 12, 10, 1, 0, 11);
        vt[13] = mk(0, 0, 0,  0,  0, 0, 0,  1, 1, 4, 6,  3,  1, 1, 7);
        vt[14] = mk(0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0,  0,  1, 2, 8);
        vt[15] = mk(0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0,  0,  1, 3, 5);
        vt[16] = mk(0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 0,  0,  0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("reset count", 64'(count), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset res_valid", 64'(res_valid), 64'd0);
        chk("reset res_tag", 64'(res_tag), 64'd0);
        chk("reset alu_op", 64'(alu_op), 64'd0);
        chk("reset alu_a", alu_a, 64'd0);
        chk("reset alu_b", alu_b, 64'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            next_cycle();
            drive(vt[i].v, vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].st, vt[i].fl);
            @(negedge clock);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d count", i), 64'(count), 64'(vt[i].e_cnt));
            chk($sformatf("vec%0d alu_op", i), 64'(alu_op), 64'(vt[i].e_op));
            chk($sformatf("vec%0d alu_a", i), alu_a, vt[i].e_a);
            chk($sformatf("vec%0d alu_b", i), alu_b, vt[i].e_b);
            chk($sformatf("vec%0d res_valid", i), 64'(res_valid), 64'(vt[i].e_rv));
            if (vt[i].e_rv) begin
                chk($sformatf("vec%0d res_tag", i), 64'(res_tag), 64'(vt[i].e_rt));
                chk($sformatf("vec%0d res_data", i), res_data, vt[i].e_rd);
            end
        end

        // Stall toggling with four queued entries: issues land on alternate cycles.
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            drive(1, 1, 64'(100 + j), 64'(j), 4'(j), 1, 0);
        end
        for (int k = 0; k < 11; k++) begin
            logic st;
            logic exp_rv;
            st = (k < 8) && (k % 2 == 0);
            exp_rv = (k == 3) || (k == 5) || (k == 7) || (k == 9);
            next_cycle();
            drive(0, 0, 0, 0, 0, st, 0);
            @(negedge clock);
            chk($sformatf("toggle k%0d alu_a", k), alu_a,
                (k < 8 && k % 2 == 1) ? 64'(100 + (k - 1) / 2) : 64'd0);
            chk($sformatf("toggle k%0d res_valid", k), 64'(res_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk($sformatf("toggle k%0d res_tag", k), 64'(res_tag), 64'((k - 3) / 2));
                chk($sformatf("toggle k%0d res_data", k), res_data, 64'(100 + (k - 3)));
            end
        end
        chk("toggle final count", 64'(count), 64'd0);

        // Flush with three queued and two in flight.
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            drive(1, 1, 64'(200 + j), 64'd1, 4'(j), 1, 0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("flush s0 alu_a", alu_a, 64'd200);
        next_cycle();
        drive(1, 1, 64'd204, 64'd1, 4'd4, 0, 0);
        @(negedge clock);
        chk("flush s1 alu_a", alu_a, 64'd201);
        chk("flush s1 in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        drive(1, 1, 64'd205, 64'd1, 4'd5, 0, 1);
        @(negedge clock);
        chk("flush s2 count", 64'(count), 64'd3);
        chk("flush s2 alu_a", alu_a, 64'd0);
        chk("flush s2 res_valid", 64'(res_valid), 64'd1);
        chk("flush s2 res_tag", 64'(res_tag), 64'd0);
        chk("flush s2 res_data", res_data, 64'd201);
        for (int k = 3; k < 6; k++) begin
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clock);
            chk($sformatf("flush s%0d count", k), 64'(count), 64'd0);
            chk($sformatf("flush s%0d in_ready", k), 64'(in_ready), 64'd1);
            chk($sformatf("flush s%0d res_valid", k), 64'(res_valid), 64'd0);
            chk($sformatf("flush s%0d alu_a", k), alu_a, 64'd0);
        end

        // Continuous push and issue with pointer and tag wrap-around.
        for (int i = 0; i < 23; i++) begin
            next_cycle();
            if (i < 20) drive(1, 1, 64'(1000 + i), 64'(i), 4'(i % 16), 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clock);
            chk($sformatf("stream i%0d count", i), 64'(count), (i >= 1 && i <= 20) ? 64'd1 : 64'd0);
            chk($sformatf("stream i%0d alu_a", i), alu_a,
                (i >= 1 && i <= 20) ? 64'(1000 + i - 1) : 64'd0);
            chk($sformatf("stream i%0d res_valid", i), 64'(res_valid), 64'(i >= 3));
            if (i >= 3) begin
                chk($sformatf("stream i%0d res_tag", i), 64'(res_tag), 64'((i - 3) % 16));
                chk($sformatf("stream i%0d res_data", i), res_data, 64'(1000 + 2 * (i - 3)));
            end
        end

        // Async reset between edges with work queued and in flight.
        next_cycle();
        drive(1, 1, 64'd50, 64'd1, 4'd7, 0, 0);
        next_cycle();
        drive(1, 1, 64'd60, 64'd1, 4'd8, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst count", 64'(count), 64'd0);
        chk("arst in_ready", 64'(in_ready), 64'd1);
        chk("arst res_valid", 64'(res_valid), 64'd0);
        chk("arst alu_op", 64'(alu_op), 64'd0);
        chk("arst alu_a", alu_a, 64'd0);
        next_cycle();
        chk("arst held res_valid", 64'(res_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            next_cycle();
            if (r == 0) drive(1, 3, 64'hF0, 64'h3C, 4'd9, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clock);
            chk($sformatf("post-reset r%0d res_valid", r), 64'(res_valid), 64'(r == 3));
            chk($sformatf("post-reset r%0d alu_a", r), alu_a, (r == 1) ? 64'hF0 : 64'd0);
            if (r == 3) begin
                chk("post-reset res_tag", 64'(res_tag), 64'd9);
                chk("post-reset res_data", res_data, 64'h30);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for the registered 64-bit ALU wrapper.
- Buffers ALU requests (op, a, b, tag) from a valid/ready producer in a small FIFO.
- Issues at most one request per cycle onto the wrapper's op/a/b inputs.
- Tracks each issued request through the wrapper's fixed latency with a valid/tag shift pipe, so the consumer gets result data paired with its tag and a valid strobe.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the request tag.
- ALU_LATENCY, 2, cycles from op/a/b driven on alu_* to the matching value on alu_out; at least 1.

Ports:
- clock  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  queue can accept; equals !full
- in_op  input  6  ALU opcode
- in_a  input  64  operand A
- in_b  input  64  operand B
- in_tag  input  TAG_W  request identifier
- stall  input  1  when high, nothing issues this cycle
- flush  input  1  synchronous: drop queued and in-flight requests
- alu_op  output  6  to wrapper io_op
- alu_a  output  64  to wrapper io_a
- alu_b  output  64  to wrapper io_b
- alu_out  input  64  from wrapper io_out
- res_valid  output  1  result valid this cycle
- res_tag  output  TAG_W  tag of the current result
- res_data  output  64  equals alu_out (combinational passthrough)
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, count=0, in_ready=1.
  - Tag pipe cleared, res_valid=0, res_tag=0.
  - alu_op/alu_a/alu_b=0.
- Push: occurs when in_valid && in_ready && !flush; entry written at the write pointer.
- in_ready:
  - Depends only on registered occupancy, never on in_valid or issue.
  - When full, a same-cycle pop does not raise in_ready.
- Issue condition: `issue = !empty && !stall && !flush`.
  - On issue, alu_op/a/b combinationally show the head entry and the entry pops at the clock edge.
  - When not issuing, alu_op/a/b are driven to 0 (not held).
- No bypass: a request pushed into an empty queue issues no earlier than the next cycle.
- Minimum latency: accept at cycle t, issue at t+1, res_valid at t+1+ALU_LATENCY.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy.
  - Simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH or underflows.
- Tag pipe:
  - ALU_LATENCY stages of {valid, tag}.
  - Stage 0 loads {issue, head tag} every cycle; later stages shift each cycle.
  - res_valid/res_tag come from the last stage.
  - The pipe is never stalled, because the wrapper pipeline has no enable; stall only inserts bubbles.
- Flush, highest priority:
  - Next cycle the FIFO is empty and all tag-pipe valids are 0.
  - No push and no issue occur in the flush cycle.
  - res_valid is 0 from the cycle after flush until new issues emerge.
  - res_valid in the flush cycle itself still reflects the pre-flush pipe.
- Reset mid-operation: all queued and in-flight requests are lost; no res_valid is generated for them.
- Ordering: strict FIFO order. Results emerge in issue order, one per cycle at most, without back-pressure (consumer must always accept).

Decomposition:
- Shared package `alu_pkg`:
  - OP_W=6 and DATA_W=64 constants.
  - ALU_LATENCY default.
  - Typedef `alu_req_t` {op, a, b, tag}.
- Natural sub-module: `sync_fifo`, a generic DEPTH x width register FIFO with push/pop/full/empty/count and synchronous clear.
- The tag pipe and issue gating remain in alu_issue_queue.

Test Plan:
- Single request: push {op=1, a=5, b=7, tag=3} at cycle 0 → alu_op=1, alu_a=5, alu_b=7 at cycle 1; res_valid=1, res_tag=3 at cycle 3; res_data equals the bench ALU model output.
- Fill to full (DEPTH=4) with stall=1 → count=4, in_ready=0, 5th in_valid not accepted. Release stall → tags issue 0,1,2,3 on consecutive cycles, then res_valid for 4 consecutive cycles with tags 0,1,2,3.
- Stall toggling 1,0,1,0 with 4 queued → issue on alternate cycles; res_valid pattern matches the issue pattern shifted by ALU_LATENCY; no tag lost or duplicated.
- Flush with 3 queued and 2 in flight → next cycle count=0, res_valid stays 0 for the next ALU_LATENCY cycles, in_ready=1.
- Continuous push and issue for 20 cycles with wrap-around → count steady at 1, tags 0..15 repeat in order, no gaps after warm-up.
- Async reset asserted mid-stream between clock edges → count=0, res_valid=0, alu_* = 0 immediately; after release, the first new request completes with 3-cycle latency.
